// File: rtl/bip_data_memory_dumper_pkg.sv
// bip_data_memory_dumper_pkg: FSM state encoding and word/byte geometry shared by the dumper.
package bip_data_memory_dumper_pkg;
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_CAPT, S_SEND, S_FIN} state_t;
    function automatic int bytes_per_word(input int nb_data, input int nb_byte);
        return nb_data / nb_byte;
    endfunction
endpackage

// File: rtl/bip_word_serializer.sv
// bip_word_serializer: parallel-load shift register that streams a word MSB byte first over valid/ready.
module bip_word_serializer #(
    parameter int NB_DATA = 16,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               en_i,
    input  logic               ready_i,
    input  logic [NB_DATA-1:0] data_i,
    output logic [NB_BYTE-1:0] tx_data_o,
    output logic               tx_valid_o,
    output logic               last_o
);
    import bip_data_memory_dumper_pkg::*;
    localparam int BPW = bytes_per_word(NB_DATA, NB_BYTE);
    localparam int NB_IDX = BPW > 1 ? $clog2(BPW) : 1;
    logic [NB_DATA-1:0] sr_q, sr_d;
    logic [NB_IDX-1:0]  idx_q, idx_d;
    logic               fire;
    always_comb begin
        fire   = en_i && ready_i;
        last_o = fire && idx_q == NB_IDX'(BPW - 1);
        sr_d   = load_i ? data_i : fire ? sr_q << NB_BYTE : sr_q;
        idx_d  = load_i ? '0 : fire ? idx_q + NB_IDX'(1) : idx_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            idx_q <= '0;
        end else begin
            sr_q  <= sr_d;
            idx_q <= idx_d;
        end
    end
    assign tx_valid_o = en_i;
    assign tx_data_o  = sr_q[NB_DATA-1 -: NB_BYTE];
endmodule

// File: rtl/bip_data_memory_dumper.sv
// bip_data_memory_dumper: reads a block of data-memory words and streams them big-endian as bytes.
module bip_data_memory_dumper #(
    parameter int NB_DATA          = 16,
    parameter int N_ADDR           = 1024,
    parameter int LOG2_N_DATA_ADDR = 10,
    parameter int NB_BYTE          = 8
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic [LOG2_N_DATA_ADDR-1:0] i_base_addr,
    input  logic [LOG2_N_DATA_ADDR:0]   i_count,
    output logic [LOG2_N_DATA_ADDR-1:0] o_mem_addr,
    output logic                        o_mem_rd,
    output logic                        o_mem_wr,
    input  logic [NB_DATA-1:0]          i_mem_data,
    output logic [NB_BYTE-1:0]          o_tx_data,
    output logic                        o_tx_valid,
    input  logic                        i_tx_ready,
    output logic                        o_busy,
    output logic                        o_done
);
    import bip_data_memory_dumper_pkg::*;
    localparam int L = LOG2_N_DATA_ADDR;
    state_t       state_q, state_d;
    logic [L-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
    logic [L:0]   rem_q, rem_d;
    logic         last;
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: if (i_start) begin
                addr_d  = i_base_addr;
                // requests larger than the memory are clamped to one full pass
                rem_d   = i_count > (L+1)'(N_ADDR) ? (L+1)'(N_ADDR) : i_count;
                state_d = i_count == '0 ? S_FIN : S_REQ;
            end
            S_REQ:  state_d = S_CAPT;
            S_CAPT: state_d = S_SEND;
            S_SEND: if (last) begin
                addr_d  = addr_q + L'(1);
                rem_d   = rem_q - (L+1)'(1);
                state_d = rem_q == (L+1)'(1) ? S_FIN : S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
        mem_addr_d = state_d == S_REQ ? addr_d : mem_addr_q;
    end
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            mem_addr_q <= mem_addr_d;
        end
    end
    bip_word_serializer #(.NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE)) u_ser (
        .clk       (i_clock),
        .rst       (i_reset),
        .load_i    (state_q == S_CAPT),
        .en_i      (state_q == S_SEND),
        .ready_i   (i_tx_ready),
        .data_i    (i_mem_data),
        .tx_data_o (o_tx_data),
        .tx_valid_o(o_tx_valid),
        .last_o    (last)
    );
    assign o_mem_addr = mem_addr_q;
    assign o_mem_rd   = state_q == S_REQ;
    assign o_mem_wr   = 1'b0;
    assign o_busy     = state_q != S_IDLE;
    assign o_done     = state_q == S_FIN;
endmodule

// File: tb/tb_bip_data_memory_dumper.sv
// tb_bip_data_memory_dumper: scoreboard bench for the data memory dumper.
module tb_bip_data_memory_dumper;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  base = '0;
    logic [10:0] count = '0;
    logic [9:0]  mem_addr;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_rdata = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy, done;

    logic [15:0] mem [0:1023];
    logic [7:0]  exp_bytes[$];
    logic [9:0]  exp_addrs[$];
    int          passed = 0, total = 0;
    int          nbytes = 0, nrd = 0, done_cnt = 0, cyc = 0, done_cyc = 0;
    bit          ready_mode = 1'b0;
    bit          held = 1'b0;
    logic [7:0]  held_data;

    bip_data_memory_dumper dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_start    (start),
        .i_base_addr(base),
        .i_count    (count),
        .o_mem_addr (mem_addr),
        .o_mem_rd   (mem_rd),
        .o_mem_wr   (mem_wr),
        .i_mem_data (mem_rdata),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_busy     (busy),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk) begin
        #1 tx_ready = ready_mode ? !tx_ready : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (mem_rd) begin
                nrd++;
                check("mem_wr", {31'd0, mem_wr}, 0);
                if (exp_addrs.size() == 0) check("unexpected_rd", {22'd0, mem_addr}, 32'hFFFF);
                else check("rd_addr", {22'd0, mem_addr}, {22'd0, exp_addrs.pop_front()});
            end
            if (held) begin
                check("hold_valid", {31'd0, tx_valid}, 1);
                check("hold_data", {24'd0, tx_data}, {24'd0, held_data});
            end
            held = tx_valid && !tx_ready;
            held_data = tx_data;
            if (tx_valid && tx_ready) begin
                nbytes++;
                if (exp_bytes.size() == 0) check("unexpected_byte", {24'd0, tx_data}, 32'hFFFF);
                else check("byte", {24'd0, tx_data}, {24'd0, exp_bytes.pop_front()});
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", {31'd0, busy}, 1);
            end
        end
    end

    task automatic expect_word(input logic [9:0] a, input logic [15:0] w);
        exp_addrs.push_back(a);
        exp_bytes.push_back(w[15:8]);
        exp_bytes.push_back(w[7:0]);
    endtask

    task automatic pulse_start(input logic [9:0] b, input logic [10:0] c);
        @(posedge clk);
        #2 start = 1'b1;
        base = b;
        count = c;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #2;
        check("done_pulses", done_cnt - d0, 1);
        check("busy_after", {31'd0, busy}, 0);
        check("bytes_left", exp_bytes.size(), 0);
        check("addrs_left", exp_addrs.size(), 0);
    endtask

    task automatic dump(input logic [9:0] b, input logic [10:0] c, input bit toggle, input bit restart, input int nexp);
        int d0 = done_cnt;
        int b0 = nbytes;
        int n = 0;
        ready_mode = toggle;
        pulse_start(b, c);
        if (restart) begin
            while (nbytes == b0 && n < 100) begin
                @(posedge clk);
                n++;
            end
            pulse_start(10'd0, 11'd5);
        end
        wait_done(d0);
        check("byte_total", nbytes - b0, nexp);
        ready_mode = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_addr"}, {22'd0, mem_addr}, 0);
        check({tag, "_rd"}, {31'd0, mem_rd}, 0);
        check({tag, "_wr"}, {31'd0, mem_wr}, 0);
        check({tag, "_data"}, {24'd0, tx_data}, 0);
        check({tag, "_valid"}, {31'd0, tx_valid}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_done"}, {31'd0, done}, 0);
    endtask

    initial begin
        int s, r0, b0, d0, n;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
        mem[5] = 16'hA1B2;
        mem[6] = 16'hC3D4;
        mem[1023] = 16'h1234;
        mem[0] = 16'h5678;
        repeat (3) @(posedge clk);
        #2 check_idle_outputs("reset");
        rst = 1'b0;

        expect_word(10'd5, 16'hA1B2);
        expect_word(10'd6, 16'hC3D4);
        dump(10'd5, 11'd2, 1'b0, 1'b0, 4);

        expect_word(10'd5, 16'hA1B2);
        expect_word(10'd6, 16'hC3D4);
        dump(10'd5, 11'd2, 1'b1, 1'b0, 4);

        expect_word(10'd1023, 16'h1234);
        expect_word(10'd0, 16'h5678);
        dump(10'd1023, 11'd2, 1'b0, 1'b0, 4);

        r0 = nrd;
        b0 = nbytes;
        d0 = done_cnt;
        @(posedge clk);
        #2 start = 1'b1;
        base = 10'd7;
        count = 11'd0;
        s = cyc;
        @(posedge clk);
        #2 start = 1'b0;
        wait_done(d0);
        check("zero_latency", done_cyc - s, 1);
        check("zero_rd", nrd - r0, 0);
        check("zero_bytes", nbytes - b0, 0);

        expect_word(10'd5, 16'hA1B2);
        expect_word(10'd6, 16'hC3D4);
        dump(10'd5, 11'd2, 1'b0, 1'b1, 4);

        expect_word(10'd5, 16'hA1B2);
        expect_word(10'd6, 16'hC3D4);
        d0 = done_cnt;
        b0 = nbytes;
        pulse_start(10'd5, 11'd2);
        n = 0;
        while (nbytes == b0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("first_byte_seen", nbytes - b0, 1);
        #1 rst = 1'b1;
        @(posedge clk);
        #2 check_idle_outputs("abort");
        rst = 1'b0;
        exp_bytes.delete();
        exp_addrs.delete();
        repeat (5) @(posedge clk);
        #2 check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle", {31'd0, busy}, 0);

        expect_word(10'd5, 16'hA1B2);
        expect_word(10'd6, 16'hC3D4);
        dump(10'd5, 11'd2, 1'b0, 1'b0, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
